// File: rtl/scic_pkg.sv
// Shared definitions for the SCIC control unit: opcodes, sequencer states,
// decode classes and bus widths.
package scic_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SHL = 4'h2;
  localparam logic [OP_W-1:0] OP_SHR = 4'h3;
  localparam logic [OP_W-1:0] OP_LI  = 4'h4;
  localparam logic [OP_W-1:0] OP_LD  = 4'h5;
  localparam logic [OP_W-1:0] OP_OR  = 4'h6;
  localparam logic [OP_W-1:0] OP_ST  = 4'h7;
  localparam logic [OP_W-1:0] OP_BR  = 4'h8;
  localparam logic [OP_W-1:0] OP_AND = 4'h9;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_OPRD   = 3'd2;
  localparam state_t ST_OPWR   = 3'd3;
  localparam state_t ST_HALT   = 3'd4;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_IMM,
    CLS_BRANCH,
    CLS_READ,
    CLS_WRITE,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/scic_decode.sv
// Opcode classifier: maps IR[31:28] onto the sequencing class the FSM needs.
module scic_decode
  import scic_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output op_class_t       op_class_c
);

  always_comb begin
    op_class_c = CLS_ILLEGAL;
    case (opcode)
      OP_NOP: op_class_c = CLS_NONE;
      OP_LI:  op_class_c = CLS_IMM;
      OP_BR:  op_class_c = CLS_BRANCH;
      OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR, OP_AND: op_class_c = CLS_READ;
      OP_ST:  op_class_c = CLS_WRITE;
      default: op_class_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/scic_sequencer.sv
// SCIC control unit: PC/IR and fetch/decode/execute sequencing over the shared bus.
// Build option SCIC_HALT_ON_ILLEGAL_EN: illegal opcodes halt instead of acting as NOP.
module scic_sequencer
  import scic_pkg::*;
#(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] operand,
  output logic [OP_W-1:0]   alu_op,
  output logic              ac_load,
  output logic              halted,
  output logic              illegal
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [DATA_W-1:0] ir, ir_nxt;
  logic [OP_W-1:0]   opcode;
  op_class_t         op_class;
  logic              unused_ir_bits;

  assign opcode         = ir[DATA_W-1 -: OP_W];
  assign operand        = ir[ADDR_W-1:0];
  assign unused_ir_bits = ^ir[DATA_W-OP_W-1:ADDR_W];

  scic_decode u_decode (
    .opcode     (opcode),
    .op_class_c (op_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= PC_W'(RESET_PC);
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  // Next state plus bus/datapath strobes; all strobes held low while reset is asserted.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    alu_op    = '0;
    ac_load   = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (!reset) begin
      case (state)
        ST_FETCH: begin
          if (run) begin
            mem_rd   = 1'b1;
            mem_addr = ADDR_W'(pc);
            if (mem_ready) begin
              ir_nxt    = mem_rdata;
              pc_nxt    = pc + PC_W'(1);
              state_nxt = ST_DECODE;
            end
          end
        end
        ST_DECODE: begin
          state_nxt = ST_FETCH;
          case (op_class)
            CLS_IMM: begin
              ac_load = 1'b1;
              alu_op  = opcode;
            end
            CLS_BRANCH: pc_nxt    = ir[PC_W-1:0];
            CLS_READ:   state_nxt = ST_OPRD;
            CLS_WRITE:  state_nxt = ST_OPWR;
            CLS_ILLEGAL: begin
              illegal = 1'b1;
`ifdef SCIC_HALT_ON_ILLEGAL_EN
              state_nxt = ST_HALT;
`else
              state_nxt = ST_FETCH;
`endif
            end
            default: state_nxt = ST_FETCH;
          endcase
        end
        ST_OPRD: begin
          mem_rd   = 1'b1;
          mem_addr = operand;
          if (mem_ready) begin
            ac_load   = 1'b1;
            alu_op    = opcode;
            state_nxt = ST_FETCH;
          end
        end
        ST_OPWR: begin
          mem_wr   = 1'b1;
          mem_addr = operand;
          if (mem_ready) state_nxt = ST_FETCH;
        end
        ST_HALT: halted = 1'b1;
        default: state_nxt = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_scic_sequencer.sv
// Directed bench for scic_sequencer: zero-wait and wait-state bus cycles, branch,
// illegal opcode, run gating, reset abort, and PC wrap on a 5-bit PC instance.
module tb_scic_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        mem_ready, mem_ready5;
  logic [31:0] mem_rdata, mem_rdata5;
  logic [15:0] mem_addr, mem_addr5, operand, operand5;
  logic        mem_rd, mem_wr, ac_load, halted, illegal;
  logic        mem_rd5, mem_wr5, ac_load5, halted5, illegal5;
  logic [3:0]  alu_op, alu_op5;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  scic_sequencer u_dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .operand   (operand),
    .alu_op    (alu_op),
    .ac_load   (ac_load),
    .halted    (halted),
    .illegal   (illegal)
  );

  scic_sequencer #(.PC_W(5), .RESET_PC(31)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .mem_addr  (mem_addr5),
    .mem_rd    (mem_rd5),
    .mem_wr    (mem_wr5),
    .mem_ready (mem_ready5),
    .mem_rdata (mem_rdata5),
    .operand   (operand5),
    .alu_op    (alu_op5),
    .ac_load   (ac_load5),
    .halted    (halted5),
    .illegal   (illegal5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    mem_ready5 = 1'b0; mem_rdata5 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd",      32'(mem_rd),   32'h0);
    chk("rst_wr",      32'(mem_wr),   32'h0);
    chk("rst_addr",    32'(mem_addr), 32'h0);
    chk("rst_acload",  32'(ac_load),  32'h0);
    chk("rst_aluop",   32'(alu_op),   32'h0);
    chk("rst_halted",  32'(halted),   32'h0);
    chk("rst_illegal", 32'(illegal),  32'h0);
    chk("rst_operand", 32'(operand),  32'h0);

    // LI 0x000F at address 0, zero wait
    reset = 1'b0; run = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h4000_000F;
    #1;
    chk("li_fetch_rd",   32'(mem_rd),   32'h1);
    chk("li_fetch_addr", 32'(mem_addr), 32'h0);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("li_acload",  32'(ac_load), 32'h1);
    chk("li_aluop",   32'(alu_op),  32'h4);
    chk("li_operand", 32'(operand), 32'h000F);
    chk("li_dec_rd",  32'(mem_rd),  32'h0);
    @(negedge clk); #1;
    chk("li_next_addr", 32'(mem_addr), 32'h1);
    chk("li_next_rd",   32'(mem_rd),   32'h1);

    // ST 0x005F with three wait cycles; run dropped mid-write must not matter
    mem_ready = 1'b1; mem_rdata = 32'h7000_005F;
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("st_dec_wr",     32'(mem_wr),  32'h0);
    chk("st_dec_acload", 32'(ac_load), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i == 3);
      run = (i != 1);
      #1;
      chk("st_wr",     32'(mem_wr),   32'h1);
      chk("st_addr",   32'(mem_addr), 32'h005F);
      chk("st_rd",     32'(mem_rd),   32'h0);
      chk("st_acload", 32'(ac_load),  32'h0);
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("st_next_addr", 32'(mem_addr), 32'h2);
    chk("st_next_rd",   32'(mem_rd),   32'h1);

    // run low during a pending fetch drops the request and holds PC
    @(negedge clk); run = 1'b0; #1;
    chk("run_low_rd", 32'(mem_rd), 32'h0);
    @(negedge clk); run = 1'b1; #1;
    chk("run_resume_rd",   32'(mem_rd),   32'h1);
    chk("run_resume_addr", 32'(mem_addr), 32'h2);

    // ADD 0x0016 with one wait cycle in OPRD
    mem_ready = 1'b1; mem_rdata = 32'h1000_0016;
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("add_dec_rd", 32'(mem_rd), 32'h0);
    @(negedge clk); #1;
    chk("add_wait_rd",     32'(mem_rd),   32'h1);
    chk("add_wait_addr",   32'(mem_addr), 32'h0016);
    chk("add_wait_acload", 32'(ac_load),  32'h0);
    chk("add_wait_aluop",  32'(alu_op),   32'h0);
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("add_rdy_acload", 32'(ac_load),  32'h1);
    chk("add_rdy_aluop",  32'(alu_op),   32'h1);
    chk("add_rdy_addr",   32'(mem_addr), 32'h0016);

    // BR 0 fetched at address 3
    @(negedge clk); mem_rdata = 32'h8000_0000; #1;
    chk("br_fetch_addr", 32'(mem_addr), 32'h3);
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("br_dec_rd", 32'(mem_rd), 32'h0);
    @(negedge clk); #1;
    chk("br_target_rd",   32'(mem_rd),   32'h1);
    chk("br_target_addr", 32'(mem_addr), 32'h0);

    // illegal opcode 0xA at address 0
    mem_ready = 1'b1; mem_rdata = 32'hA000_1234;
    @(negedge clk); mem_ready = 1'b0; #1;
    chk("ill_pulse",  32'(illegal), 32'h1);
    chk("ill_acload", 32'(ac_load), 32'h0);
    @(negedge clk); #1;
    chk("ill_pulse_off", 32'(illegal), 32'h0);
`ifdef SCIC_HALT_ON_ILLEGAL_EN
    chk("ill_halted", 32'(halted), 32'h1);
    chk("ill_rd",     32'(mem_rd), 32'h0);
    @(negedge clk); #1;
    chk("halt_hold",  32'(halted), 32'h1);
    chk("halt_rd",    32'(mem_rd), 32'h0);
    chk("halt_wr",    32'(mem_wr), 32'h0);
`else
    chk("ill_halted",    32'(halted),   32'h0);
    chk("ill_next_rd",   32'(mem_rd),   32'h1);
    chk("ill_next_addr", 32'(mem_addr), 32'h1);
`endif

    // reset back to RESET_PC, then abort an LD mid-wait with reset
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    chk("rst2_addr",   32'(mem_addr), 32'h0);
    chk("rst2_halted", 32'(halted),   32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h5000_0030;
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("ld_wait_rd",   32'(mem_rd),   32'h1);
    chk("ld_wait_addr", 32'(mem_addr), 32'h0030);
    reset = 1'b1;
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("rstab_rd",     32'(mem_rd),   32'h0);
    chk("rstab_acload", 32'(ac_load),  32'h0);
    chk("rstab_addr",   32'(mem_addr), 32'h0);
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0; #1;
    chk("rstab_fetch_rd",   32'(mem_rd),   32'h1);
    chk("rstab_fetch_addr", 32'(mem_addr), 32'h0);

    // 5-bit PC: NOP at 0x1F wraps the next fetch to 0
    chk("w5_fetch_rd",   32'(mem_rd5),   32'h1);
    chk("w5_fetch_addr", 32'(mem_addr5), 32'h1F);
    mem_ready5 = 1'b1; mem_rdata5 = 32'h0;
    @(negedge clk); mem_ready5 = 1'b0; #1;
    chk("w5_dec_rd",      32'(mem_rd5),   32'h0);
    chk("w5_dec_wr",      32'(mem_wr5),   32'h0);
    chk("w5_dec_acload",  32'(ac_load5),  32'h0);
    chk("w5_dec_aluop",   32'(alu_op5),   32'h0);
    chk("w5_dec_illegal", 32'(illegal5),  32'h0);
    chk("w5_dec_halted",  32'(halted5),   32'h0);
    chk("w5_dec_operand", 32'(operand5),  32'h0);
    @(negedge clk); #1;
    chk("w5_wrap_rd",   32'(mem_rd5),   32'h1);
    chk("w5_wrap_addr", 32'(mem_addr5), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
